// File: rtl/noc_switch_pkg.sv
// Shared flit-type encodings and arbitration state for the switch output-port logic.
`default_nettype none

package noc_switch_pkg;

  localparam int FLIT_ID_W = 2;

  localparam logic [FLIT_ID_W-1:0] HEAD     = 2'b10;
  localparam logic [FLIT_ID_W-1:0] BODY     = 2'b00;
  localparam logic [FLIT_ID_W-1:0] TAIL     = 2'b01;
  localparam logic [FLIT_ID_W-1:0] HEADTAIL = 2'b11;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic is_head_flit(input logic [FLIT_ID_W-1:0] id);
    return (id == HEAD) || (id == HEADTAIL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set bit of cand at or above ptr, wrapping to index 0.
`default_nettype none

module rr_select #(
  parameter int N     = 5,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     cand,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [N-1:0] upper;
  logic         found;

  // Candidates at or above the pointer win first; otherwise wrap to the lowest candidate.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      upper[j] = cand[j] && (j >= int'(ptr));
    end
    for (int j = 0; j < N; j++) begin
      if (!found && upper[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && cand[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wormhole_grant_ctrl.sv
// Output-port grant lock: round-robin tie break, then hold grant until the packet tail (wormhole).
// Optional stall timeout on a held lock is enabled with macro GRANT_TIMEOUT_EN.
`default_nettype none

module wormhole_grant_ctrl #(
  parameter int IN_N        = 5,
  parameter int FLIT_ID_W   = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [IN_N-1:0]                req_i,
  input  logic [IN_N-1:0][FLIT_ID_W-1:0] flit_id_i,
  input  logic [IN_N-1:0]                hop_vld_i,
  input  logic                           not_conclusive_i,
  input  logic                           out_rdy_i,
  output logic [IN_N-1:0]                grant_o,
  output logic                           xfer_o,
`ifdef GRANT_TIMEOUT_EN
  output logic                           timeout_o,
`endif
  output logic                           busy_o
);

  import noc_switch_pkg::*;

  localparam int PTR_W = (IN_N > 1) ? $clog2(IN_N) : 1;

  if (IN_N < 2) begin : g_in_n_chk
    $error("IN_N must be at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_timeout_chk
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] lock_idx_q, lock_idx_d;
  logic [PTR_W-1:0] sel_ptr, win_idx;
  logic [IN_N-1:0]  is_head, cand, rr_grant;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    return (v == PTR_W'(IN_N - 1)) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < IN_N; i++) begin
      is_head[i] = is_head_flit(flit_id_i[i]);
    end
  end

  assign cand    = req_i & hop_vld_i & is_head;
  // A conclusive hop-count result is a lowest-index pick, i.e. round-robin from 0.
  assign sel_ptr = not_conclusive_i ? rr_ptr_q : '0;

  rr_select #(
    .N     (IN_N),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .cand  (cand),
    .ptr   (sel_ptr),
    .grant (rr_grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < IN_N; i++) begin
      if (rr_grant[i]) win_idx = PTR_W'(i);
    end
  end

`ifdef GRANT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    grant_o    = '0;
    xfer_o     = 1'b0;
`ifdef GRANT_TIMEOUT_EN
    stall_d    = stall_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      LOCKED: begin
        grant_o[lock_idx_q] = 1'b1;
        xfer_o              = req_i[lock_idx_q] & out_rdy_i;
        // Stray HEAD/HEADTAIL inside a packet falls through as BODY.
        if (xfer_o && (flit_id_i[lock_idx_q] == TAIL)) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_inc(lock_idx_q);
        end
`ifdef GRANT_TIMEOUT_EN
        if (xfer_o) begin
          stall_d = '0;
        end else if (stall_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d   = IDLE;
          rr_ptr_d  = wrap_inc(lock_idx_q);
          stall_d   = '0;
          timeout_d = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      default: begin
        grant_o = rr_grant;
        xfer_o  = (|rr_grant) & out_rdy_i;
`ifdef GRANT_TIMEOUT_EN
        stall_d = '0;
`endif
        if (xfer_o) begin
          if (flit_id_i[win_idx] == HEADTAIL) begin
            rr_ptr_d = wrap_inc(win_idx);
          end else begin
            state_d    = LOCKED;
            lock_idx_d = win_idx;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
`ifdef GRANT_TIMEOUT_EN
      stall_q    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
`ifdef GRANT_TIMEOUT_EN
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign busy_o = (state_q == LOCKED);
`ifdef GRANT_TIMEOUT_EN
  assign timeout_o = timeout_q;
`endif

`ifndef SYNTHESIS
  head_in_locked_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((state_q == LOCKED) && xfer_o && is_head[lock_idx_q]));
`endif

endmodule

`default_nettype wire

// File: tb/tb_wormhole_grant_ctrl.sv
// Directed bench for wormhole_grant_ctrl with a per-cycle reference model and literal spot checks.
`default_nettype none

module tb_wormhole_grant_ctrl;

  localparam int N  = 5;
  localparam int TO = 16;
  localparam logic [1:0] F_HEAD = 2'b10, F_BODY = 2'b00, F_TAIL = 2'b01, F_HT = 2'b11;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, hop_vld;
  logic [N-1:0][1:0] flit;
  logic            nc, rdy;
  logic [N-1:0]    grant;
  logic            xfer, busy;
`ifdef GRANT_TIMEOUT_EN
  logic            timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  bit m_locked;
  int m_lock, m_rr, m_stall;
  bit m_timeout;

  always #5 clk = ~clk;

  wormhole_grant_ctrl #(.IN_N(N), .FLIT_ID_W(2), .TIMEOUT_CYC(TO)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_i            (req),
    .flit_id_i        (flit),
    .hop_vld_i        (hop_vld),
    .not_conclusive_i (nc),
    .out_rdy_i        (rdy),
    .grant_o          (grant),
    .xfer_o           (xfer),
`ifdef GRANT_TIMEOUT_EN
    .timeout_o        (timeout),
`endif
    .busy_o           (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_outputs(output logic [N-1:0] g, output logic x);
    logic [N-1:0] cand;
    int start, j;
    bit found;
    g = '0;
    if (m_locked) begin
      g[m_lock] = 1'b1;
      x = req[m_lock] & rdy;
    end else begin
      for (int i = 0; i < N; i++)
        cand[i] = req[i] & hop_vld[i] & ((flit[i] == F_HEAD) || (flit[i] == F_HT));
      start = nc ? m_rr : 0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        j = (start + k) % N;
        if (!found && cand[j]) begin
          g[j]  = 1'b1;
          found = 1'b1;
        end
      end
      x = found & rdy;
    end
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] g;
    logic x;
    int gi;
    if (!rst_n) begin
      m_locked = 1'b0; m_lock = 0; m_rr = 0; m_stall = 0; m_timeout = 1'b0;
    end else begin
      model_outputs(g, x);
      m_timeout = 1'b0;
      gi = 0;
      for (int i = 0; i < N; i++) if (g[i]) gi = i;
      if (!m_locked) begin
        m_stall = 0;
        if (x) begin
          if (flit[gi] == F_HT) m_rr = (gi + 1) % N;
          else begin m_locked = 1'b1; m_lock = gi; end
        end
      end else if (x) begin
        m_stall = 0;
        if (flit[m_lock] == F_TAIL) begin m_locked = 1'b0; m_rr = (m_lock + 1) % N; end
      end else begin
`ifdef GRANT_TIMEOUT_EN
        m_stall++;
        if (m_stall == TO) begin
          m_locked = 1'b0; m_rr = (m_lock + 1) % N; m_stall = 0; m_timeout = 1'b1;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] g;
    logic x;
    if (chk_en) begin
      model_outputs(g, x);
      chk("model_grant", grant, g);
      chk("model_xfer", xfer, x);
      chk("model_busy", busy, m_locked);
`ifdef GRANT_TIMEOUT_EN
      chk("model_timeout", timeout, m_timeout);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] g, input logic x, input logic b);
    #1;
    chk({name, "_grant"}, grant, g);
    chk({name, "_xfer"}, xfer, x);
    chk({name, "_busy"}, busy, b);
  endtask

  task automatic clear_inputs();
    req = '0; hop_vld = '0; nc = 1'b0; rdy = 1'b1;
    for (int i = 0; i < N; i++) flit[i] = F_BODY;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    step(); step();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    expect_out("reset", 5'b00000, 1'b0, 1'b0);
`ifdef GRANT_TIMEOUT_EN
    chk("reset_timeout", timeout, 1'b0);
`endif
    step();

    // Single 3-flit packet on input 2
    req = 5'b00100; hop_vld = 5'b00100; flit[2] = F_HEAD;
    expect_out("pkt_head", 5'b00100, 1'b1, 1'b0); step();
    hop_vld = '0; flit[2] = F_BODY;
    expect_out("pkt_body", 5'b00100, 1'b1, 1'b1); step();
    flit[2] = F_TAIL;
    expect_out("pkt_tail", 5'b00100, 1'b1, 1'b1); step();
    req = '0;
    expect_out("pkt_after", 5'b00000, 1'b0, 1'b0); step();

    // Ties over inputs 0,1,4; first pick shows rr_ptr = 3 after the packet
    req = 5'b10011; hop_vld = 5'b10011; nc = 1'b1;
    for (int i = 0; i < N; i++) flit[i] = F_HT;
    expect_out("tie_rr3", 5'b10000, 1'b1, 1'b0); step();
    expect_out("tie_rr0", 5'b00001, 1'b1, 1'b0); step();
    expect_out("tie_a", 5'b00010, 1'b1, 1'b0); step();
    expect_out("tie_b", 5'b10000, 1'b1, 1'b0); step();
    expect_out("tie_c", 5'b00001, 1'b1, 1'b0); step();
    clear_inputs();

    // Lock hold on input 0 while input 3 presents a HEAD
    req = 5'b00001; hop_vld = 5'b00001; flit[0] = F_HEAD;
    expect_out("hold_head", 5'b00001, 1'b1, 1'b0); step();
    req = 5'b01001; flit[0] = F_BODY; flit[3] = F_HEAD; hop_vld = 5'b01000;
    expect_out("hold_body", 5'b00001, 1'b1, 1'b1); step();
    req = 5'b01000;
    expect_out("hold_gap", 5'b00001, 1'b0, 1'b1); step();
    req = 5'b01001; flit[0] = F_TAIL;
    expect_out("hold_tail", 5'b00001, 1'b1, 1'b1); step();
    req = 5'b01000;
    expect_out("hold_next", 5'b01000, 1'b1, 1'b0); step();

    // Backpressure on input 3's tail
    flit[3] = F_BODY;
    expect_out("bp_body", 5'b01000, 1'b1, 1'b1); step();
    flit[3] = F_TAIL; rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_out("bp_stall", 5'b01000, 1'b0, 1'b1); step();
    end
    rdy = 1'b1;
    expect_out("bp_tail", 5'b01000, 1'b1, 1'b1); step();
    clear_inputs();
    expect_out("bp_idle", 5'b00000, 1'b0, 1'b0); step();

    // BODY while IDLE is ignored; IDLE HEAD with backpressure re-evaluates
    req = 5'b00010; hop_vld = 5'b00010; flit[1] = F_BODY;
    expect_out("idle_body", 5'b00000, 1'b0, 1'b0); step();
    flit[1] = F_HEAD; rdy = 1'b0;
    expect_out("idle_bp0", 5'b00010, 1'b0, 1'b0); step();
    expect_out("idle_bp1", 5'b00010, 1'b0, 1'b0); step();
    rdy = 1'b1;
    expect_out("idle_go", 5'b00010, 1'b1, 1'b0); step();
    flit[1] = F_BODY;
    expect_out("rst_locked", 5'b00010, 1'b1, 1'b1); step();

    // Reset mid-packet on input 1
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    expect_out("rst_after", 5'b00000, 1'b0, 1'b0);
    req = 5'b10010; hop_vld = 5'b10010; nc = 1'b1; flit[1] = F_HT; flit[4] = F_HT;
    expect_out("rst_rr0", 5'b00010, 1'b1, 1'b0); step();
    expect_out("rst_rr2", 5'b10000, 1'b1, 1'b0); step();
    clear_inputs();

`ifdef GRANT_TIMEOUT_EN
    // Stall timeout on input 2
    req = 5'b00100; hop_vld = 5'b00100; flit[2] = F_HEAD;
    expect_out("to_head", 5'b00100, 1'b1, 1'b0); step();
    req = '0; flit[2] = F_BODY;
    for (int i = 0; i < TO; i++) begin
      expect_out("to_stall", 5'b00100, 1'b0, 1'b1);
      chk("to_quiet", timeout, 1'b0);
      step();
    end
    expect_out("to_fire", 5'b00000, 1'b0, 1'b0);
    chk("to_pulse", timeout, 1'b1);
    step();
    chk("to_once", timeout, 1'b0);
    req = 5'b11001; hop_vld = 5'b11001; nc = 1'b1;
    flit[0] = F_HT; flit[3] = F_HT; flit[4] = F_HT;
    expect_out("to_rr3", 5'b01000, 1'b1, 1'b0); step();
    clear_inputs();
`endif

    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wormhole_grant_ctrl.md
Name: wormhole_grant_ctrl

Overview:
Downstream stage of the hop-count arbiter in each switch output port. It takes the hop-count-filtered request vector and the tie flag. On a tie it resolves the winner round-robin. It then locks the grant to the winning input until that packet's tail flit has been transferred (wormhole switching). The one-hot grant drives the crossbar select for that output.

Parameters:
IN_N, 5, number of switch inputs competing for this output
FLIT_ID_W, 2, width of the flit-type field
TIMEOUT_CYC, 16, lock-stall limit in cycles; used only with the optional feature

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; synchronous, active-low
req_i  input  IN_N  input buffer i has a flit for this output
flit_id_i  input  IN_N x FLIT_ID_W  type of the flit at the head of each input buffer
hop_vld_i  input  IN_N  max-hop-count candidates, from hop-count arbiter vld_input_o
not_conclusive_i  input  1  tie flag, from hop-count arbiter
out_rdy_i  input  1  downstream buffer can accept a flit this cycle
grant_o  output  IN_N  one-hot crossbar select; all zero when no grant
xfer_o  output  1  flit transferred this cycle (grant_o != 0 and out_rdy_i)
busy_o  output  1  lock held (state LOCKED)
timeout_o  output  1  one-cycle stall-timeout pulse; present only with the optional feature

Behaviour:
- Reset (rst_ni low at a clock edge) sets:
  - state IDLE, rr_ptr 0
  - grant_o 0, busy_o 0, timeout_o 0
- Reset mid-packet drops the lock immediately. No flush is performed.
- Flit types, from the package: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, HEADTAIL=2'b11.
- Candidate vector: cand = req_i & hop_vld_i & is_head. is_head[i] is true when flit_id_i[i] is HEAD or HEADTAIL.
- IDLE state, grant selection (combinational, zero-latency):
  - not_conclusive_i=0: grant_o = lowest-index set bit of cand. The upstream block guarantees at most one bit.
  - not_conclusive_i=1: grant_o = first set bit of cand, searching from index rr_ptr upward with wrap-around modulo IN_N.
  - cand=0: grant_o=0. This holds even when req_i is non-zero, e.g. a BODY flit while IDLE, which is ignored.
- IDLE state, transitions when xfer_o:
  - Granted flit is HEAD: go to LOCKED, registering lock_idx = granted index.
  - Granted flit is HEADTAIL: stay IDLE and set rr_ptr = (granted index + 1) mod IN_N.
  - When grant_o!=0 but out_rdy_i=0: no state change, and the grant is re-evaluated next cycle.
- LOCKED state:
  - grant_o = onehot(lock_idx), independent of hop_vld_i, not_conclusive_i and req_i of other inputs.
  - xfer_o = req_i[lock_idx] & out_rdy_i.
  - A gap (req_i[lock_idx]=0) keeps the lock; xfer_o is 0.
  - On xfer_o with flit TAIL: go to IDLE and set rr_ptr = (lock_idx + 1) mod IN_N.
  - A new arbitration happens the cycle after the tail. There is no same-cycle tail-to-head handover.
  - On xfer_o with flit BODY: stay LOCKED.
  - A HEAD or HEADTAIL flit arriving while LOCKED is a protocol error. It is treated as BODY, and a simulation-only assertion fires.
- Width rules:
  - rr_ptr is $clog2(IN_N) bits.
  - rr_ptr and lock_idx increment with explicit wrap: IN_N-1 -> 0.
- Simultaneous events: out_rdy_i falling in the cycle of a tail means no transfer, so the lock is retained.

Optional Feature:
Macro GRANT_TIMEOUT_EN.
- Defined:
  - Adds a stall counter of $clog2(TIMEOUT_CYC+1) bits, cleared on reset, on entry to LOCKED, and on every xfer_o.
  - The counter increments each LOCKED cycle without xfer_o.
  - When it reaches TIMEOUT_CYC, the block forces IDLE, sets rr_ptr = lock_idx+1, and pulses timeout_o for one cycle.
- Not defined: no counter exists, the lock is held indefinitely, and timeout_o is not present.

Decomposition:
- Package noc_switch_pkg:
  - flit-id localparams HEAD/BODY/TAIL/HEADTAIL
  - FLIT_ID_W
  - state enum {IDLE, LOCKED}
- Sub-module rr_select: a purely combinational round-robin picker with inputs cand and rr_ptr, and a one-hot output. It is reusable by the input-side VC allocator.

Test Plan:
- Single 3-flit packet: input 2 sends HEAD/BODY/TAIL, not_conclusive_i=0, out_rdy_i=1. Expect grant_o=5'b00100 for 3 cycles, busy_o 1 on cycles 2-3, IDLE afterwards, rr_ptr=3.
- Tie resolution: cand=5'b10011, not_conclusive_i=1, rr_ptr=1, all HEADTAIL. Expect grant order 1, 4, 0, with rr_ptr 2, 0, 1.
- Lock hold: input 0 is LOCKED while input 3 presents HEAD with hop_vld_i=5'b01000. Expect grant_o to stay 5'b00001 until input 0's TAIL, then 5'b01000 on the next cycle.
- Backpressure: out_rdy_i=0 for 4 cycles during the tail. Expect xfer_o=0 and busy_o=1 throughout; the tail transfers on the first out_rdy_i=1 cycle.
- Reset mid-packet: rst_ni=0 for 1 cycle while LOCKED on input 1. Expect grant_o=0 and busy_o=0 on the next cycle, with rr_ptr=0.
- GRANT_TIMEOUT_EN: LOCKED on input 2 with req_i[2]=0 for 16 cycles. Expect timeout_o high for exactly one cycle, then IDLE and rr_ptr=3.
